// File: rtl/ysyx_22050039_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state codes, trap causes
// and the latched decoder flags.
package ysyx_22050039_seq_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_ILL  = 2'd1,
    CAUSE_IFTO = 2'd2,
    CAUSE_DMTO = 2'd3
  } cause_e;

  // Decoder outputs captured in DECODE; later states look only at these.
  typedef struct packed {
    logic wreg;
    logic wpc;
    logic mem;
    logic store;
  } dec_flags_t;

endpackage

// File: rtl/ysyx_22050039_wait_timer.sv
// Response wait counter shared by FETCH and MEM; o_expired flags that the
// count has reached TIMEOUT.
module ysyx_22050039_wait_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/[MEM]/WB with write strobes.
// Optional cycle/instret counters under YSYX_22050039_PERF_CNT_EN.
module ysyx_22050039_seq_ctrl
  import ysyx_22050039_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned XLEN    = 64
) (
  input  logic               clk,
  input  logic               rst,
`ifdef YSYX_22050039_PERF_CNT_EN
  output logic [XLEN-1:0]    cycle_cnt,
  output logic [XLEN-1:0]    instret_cnt,
`endif
  output logic               imem_req,
  input  logic               imem_rvalid,
  output logic               ir_wen,
  input  logic               dec_wreg,
  input  logic               dec_wpc,
  input  logic               dec_mem,
  input  logic               dec_store,
  input  logic               dec_ebreak,
  input  logic               dec_invalid,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_done,
  output logic               reg_wen,
  output logic               pc_wen,
  output logic               pc_inc,
  output logic               halt,
  output logic               trap,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic [STATE_W-1:0] state
);

  if ((2 ** CNT_W) <= TIMEOUT || XLEN == 0) begin : g_bad_params
    $error("seq_ctrl: CNT_W too narrow for TIMEOUT, or XLEN is zero");
  end

  state_e     r_state;
  dec_flags_t r_flags;
  logic       r_halt;
  logic       r_trap;
  cause_e     r_cause;

  logic w_wait_st;
  logic w_resp;
  logic w_expired;

  // Counter runs only while waiting in FETCH/MEM; any response or other state clears it.
  assign w_wait_st = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_resp    = (r_state == ST_FETCH) ? imem_rvalid : dmem_done;

  ysyx_22050039_wait_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_wait_st || w_resp),
    .i_en      (w_wait_st && !w_resp),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_FETCH;
      r_flags <= '0;
      r_halt  <= 1'b0;
      r_trap  <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_rvalid) begin
            r_state <= ST_DECODE;
          end else if (w_expired) begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_IFTO;
          end
        end
        ST_DECODE: begin
          r_flags <= '{wreg: dec_wreg, wpc: dec_wpc, mem: dec_mem,
                       store: dec_mem & dec_store};
          if (dec_invalid) begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_ILL;
          end else if (dec_ebreak) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: r_state <= r_flags.mem ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (dmem_done) begin
            r_state <= ST_WB;
          end else if (w_expired) begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_DMTO;
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        ST_TRAP: r_state <= ST_TRAP;
        default: begin
          r_state <= ST_TRAP;
          r_trap  <= 1'b1;
          r_cause <= CAUSE_ILL;
        end
      endcase
    end
  end

  // Requests and strobes decode straight from the state register; ir_wen also needs rvalid.
  assign imem_req   = (r_state == ST_FETCH);
  assign ir_wen     = (r_state == ST_FETCH) && imem_rvalid;
  assign dmem_req   = (r_state == ST_MEM);
  assign dmem_we    = (r_state == ST_MEM) && r_flags.store;
  assign reg_wen    = (r_state == ST_WB) && r_flags.wreg;
  assign pc_wen     = (r_state == ST_WB) && r_flags.wpc;
  assign pc_inc     = (r_state == ST_WB) && !r_flags.wpc;
  assign halt       = r_halt;
  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign state      = r_state;

`ifdef YSYX_22050039_PERF_CNT_EN
  logic [XLEN-1:0] r_cycle;
  logic [XLEN-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (r_state != ST_HALT && r_state != ST_TRAP) r_cycle <= r_cycle + XLEN'(1);
      if (r_state == ST_WB) r_instret <= r_instret + XLEN'(1);
    end
  end

  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;
`endif

endmodule

// File: tb/tb_ysyx_22050039_seq_ctrl.sv
// Directed bench for ysyx_22050039_seq_ctrl; counter checks run when
// YSYX_22050039_PERF_CNT_EN is defined.
module tb_ysyx_22050039_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       imem_req, imem_rvalid, ir_wen;
  logic       dec_wreg, dec_wpc, dec_mem, dec_store, dec_ebreak, dec_invalid;
  logic       dmem_req, dmem_we, dmem_done;
  logic       reg_wen, pc_wen, pc_inc, halt, trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
`ifdef YSYX_22050039_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_22050039_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef YSYX_22050039_PERF_CNT_EN
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
`endif
    .imem_req    (imem_req),
    .imem_rvalid (imem_rvalid),
    .ir_wen      (ir_wen),
    .dec_wreg    (dec_wreg),
    .dec_wpc     (dec_wpc),
    .dec_mem     (dec_mem),
    .dec_store   (dec_store),
    .dec_ebreak  (dec_ebreak),
    .dec_invalid (dec_invalid),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_done   (dmem_done),
    .reg_wen     (reg_wen),
    .pc_wen      (pc_wen),
    .pc_inc      (pc_inc),
    .halt        (halt),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_rvalid = 0; dmem_done = 0;
    dec_wreg = 0; dec_wpc = 0; dec_mem = 0; dec_store = 0;
    dec_ebreak = 0; dec_invalid = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic chk_strobes_low(input string tag);
    chk({tag, ".ir_wen"}, ir_wen, 0);
    chk({tag, ".dmem_req"}, dmem_req, 0);
    chk({tag, ".dmem_we"}, dmem_we, 0);
    chk({tag, ".reg_wen"}, reg_wen, 0);
    chk({tag, ".pc_wen"}, pc_wen, 0);
    chk({tag, ".pc_inc"}, pc_inc, 0);
  endtask

  // Fetch one word and step it to completion; dly = cycles before dmem_done.
  task automatic exec_instr(input string tag, input logic wreg, input logic wpc,
                            input logic mem, input logic store, input int dly,
                            output int cyc, output int nreq);
    cyc = 0; nreq = 0;
    chk({tag, ".f_state"}, state, 0);
    imem_rvalid = 1; #1;
    chk({tag, ".ir_wen"}, ir_wen, 1);
    tick(); imem_rvalid = 0; cyc++;
    chk({tag, ".d_state"}, state, 1);
    chk({tag, ".d_ir_wen"}, ir_wen, 0);
    dec_wreg = wreg; dec_wpc = wpc; dec_mem = mem; dec_store = store;
    tick(); cyc++;
    clear_inputs();
    chk({tag, ".e_state"}, state, 2);
    imem_rvalid = 1; #1;
    chk({tag, ".e_stray_rvalid"}, ir_wen, 0);
    tick(); imem_rvalid = 0; cyc++;
    if (mem) begin
      for (int k = 0; k <= dly; k++) begin
        chk({tag, ".m_state"}, state, 3);
        chk({tag, ".m_we"}, dmem_we, store);
        if (dmem_req) nreq++;
        if (k == dly) dmem_done = 1;
        tick(); dmem_done = 0; cyc++;
      end
    end
    chk({tag, ".w_state"}, state, 4);
    chk({tag, ".w_reg_wen"}, reg_wen, wreg);
    chk({tag, ".w_pc_wen"}, pc_wen, wpc);
    chk({tag, ".w_pc_inc"}, pc_inc, !wpc);
    chk({tag, ".w_dmem_req"}, dmem_req, 0);
    tick(); cyc++;
    chk({tag, ".end_state"}, state, 0);
  endtask

  initial begin
    int cyc, nreq, n;

    // Reset values
    rst = 0;
    clear_inputs();
    tick(); tick();
    chk("rst.state", state, 0);
    chk_strobes_low("rst");
    chk("rst.halt", halt, 0);
    chk("rst.trap", trap, 0);
    chk("rst.cause", trap_cause, 0);
    rst = 1;

    exec_instr("addi", 1, 0, 0, 0, 0, cyc, nreq);
    chk("addi.cycles", cyc, 4);
    exec_instr("jal", 1, 1, 0, 0, 0, cyc, nreq);
    chk("jal.cycles", cyc, 4);
    exec_instr("sd", 0, 0, 1, 1, 3, cyc, nreq);
    chk("sd.cycles", cyc, 8);
    chk("sd.req_cycles", nreq, 4);
    exec_instr("ld", 1, 0, 1, 0, 0, cyc, nreq);
    chk("ld.cycles", cyc, 5);
    chk("ld.req_cycles", nreq, 1);

    // invalid + ebreak together: invalid wins
    imem_rvalid = 1; tick(); imem_rvalid = 0;
    dec_invalid = 1; dec_ebreak = 1; tick(); clear_inputs();
    chk("ill.state", state, 6);
    chk("ill.trap", trap, 1);
    chk("ill.halt", halt, 0);
    chk("ill.cause", trap_cause, 1);
    imem_rvalid = 1; dmem_done = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill.sticky_state", state, 6);
      chk("ill.imem_req", imem_req, 0);
      chk_strobes_low("ill");
    end
    do_reset();
    chk("ill.rst_state", state, 0);
    chk("ill.rst_trap", trap, 0);
    chk("ill.rst_cause", trap_cause, 0);

    // ebreak alone
    imem_rvalid = 1; tick(); imem_rvalid = 0;
    dec_ebreak = 1; tick(); clear_inputs();
    chk("ebrk.state", state, 5);
    chk("ebrk.halt", halt, 1);
    chk("ebrk.trap", trap, 0);
    chk("ebrk.cause", trap_cause, 0);
    imem_rvalid = 1; tick();
    chk("ebrk.imem_req", imem_req, 0);
    chk("ebrk.ir_wen", ir_wen, 0);
    do_reset();

    // ifetch timeout: 256 FETCH cycles then TRAP cause 2
    n = 0;
    while (state == 0 && n < 400) begin n++; tick(); end
    chk("ifto.fetch_cycles", n, 256);
    chk("ifto.state", state, 6);
    chk("ifto.cause", trap_cause, 2);
    do_reset();

    // dmem timeout: 256 MEM cycles then TRAP cause 3
    imem_rvalid = 1; tick(); imem_rvalid = 0;
    dec_mem = 1; dec_wreg = 1; tick(); clear_inputs();
    tick();
    n = 0;
    while (state == 3 && n < 400) begin n++; tick(); end
    chk("dmto.mem_cycles", n, 256);
    chk("dmto.state", state, 6);
    chk("dmto.cause", trap_cause, 3);
    do_reset();

    // reset asserted mid-MEM
    imem_rvalid = 1; tick(); imem_rvalid = 0;
    dec_mem = 1; dec_store = 1; tick(); clear_inputs();
    tick(); tick();
    chk("mrst.pre_state", state, 3);
    chk("mrst.pre_req", dmem_req, 1);
    rst = 0; tick();
    chk("mrst.state", state, 0);
    chk_strobes_low("mrst");
    chk("mrst.halt", halt, 0);
    chk("mrst.trap", trap, 0);
    rst = 1;
    exec_instr("post_rst", 1, 0, 0, 0, 0, cyc, nreq);
    chk("post_rst.cycles", cyc, 4);

`ifdef YSYX_22050039_PERF_CNT_EN
    do_reset();
    chk("perf.rst_cycle", cycle_cnt, 0);
    chk("perf.rst_instret", instret_cnt, 0);
    for (int i = 0; i < 3; i++) exec_instr("perf_alu", 1, 0, 0, 0, 0, cyc, nreq);
    imem_rvalid = 1; tick(); imem_rvalid = 0;
    dec_ebreak = 1; tick(); clear_inputs();
    chk("perf.halt_state", state, 5);
    chk("perf.instret", instret_cnt, 3);
    chk("perf.cycle", cycle_cnt, 14);
    tick(); tick(); tick();
    chk("perf.cycle_frozen", cycle_cnt, 14);
    chk("perf.instret_frozen", instret_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
